// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default datapath widths, the EX/MEM bundle
// layout and the state encoding of the two-entry skid register.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_W  = 5;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] alu_result;
    logic [DEFAULT_DATA_W-1:0] store_data;
    logic [DEFAULT_REG_W-1:0]  rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } ex_mem_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic [1:0] stateOccupancy(input skid_state_t s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/ex_mem_skid_reg.sv
// Two-entry elastic EX/MEM pipeline register (head + skid) with a qualified
// forwarding tag/data taken from the head entry only.
module ex_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_W  = DEFAULT_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [REG_W-1:0]  ex_mem_rd,
  output logic [DATA_W-1:0] ex_mem_fwd_data,
  output logic [1:0]        occupancy
);

  // Same field layout as pipe_pkg::ex_mem_bundle_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } bundleT;

  skid_state_t state;
  skid_state_t stateNext;
  bundleT      head;
  bundleT      skid;
  bundleT      inBundle;
  logic        exReadyQ;
  logic        headValid;
  logic        push;
  logic        pop;
  logic        loadHeadFromIn;
  logic        loadHeadFromSkid;
  logic        loadSkid;
  logic        fwdHit;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid must not depend on ready, and ready here comes from a flop.
  assign headValid = (state != EMPTY);
  assign push      = ex_valid && exReadyQ;
  assign pop       = headValid && mem_ready;

  assign inBundle = '{
    alu_result: ex_alu_result,
    store_data: ex_store_data,
    rd:         ex_rd,
    reg_write:  ex_reg_write,
    mem_read:   ex_mem_read,
    mem_write:  ex_mem_write
  };

  always_comb begin
    stateNext        = state;
    loadHeadFromIn   = 1'b0;
    loadHeadFromSkid = 1'b0;
    loadSkid         = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            stateNext      = ONE;
            loadHeadFromIn = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            loadHeadFromIn = 1'b1;
          end else if (push) begin
            stateNext = FULL;
            loadSkid  = 1'b1;
          end else if (pop) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          // ex_ready is low here, so only a pop can move the state.
          if (pop) begin
            stateNext        = ONE;
            loadHeadFromSkid = 1'b1;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      head     <= '0;
      skid     <= '0;
      exReadyQ <= 1'b1;
    end else begin
      state    <= stateNext;
      exReadyQ <= (stateNext != FULL);
      if (loadHeadFromIn) begin
        head <= inBundle;
      end else if (loadHeadFromSkid) begin
        head <= skid;
      end
      if (loadSkid) begin
        skid <= inBundle;
      end
    end
  end

  assign ex_ready  = exReadyQ;
  assign mem_valid = headValid;
  assign occupancy = stateOccupancy(state);

  // Payload passes through untouched; control bits are masked by the head valid.
  assign mem_alu_result = head.alu_result;
  assign mem_store_data = head.store_data;
  assign mem_rd         = head.rd;
  assign mem_reg_write  = headValid && head.reg_write;
  assign mem_mem_read   = headValid && head.mem_read;
  assign mem_mem_write  = headValid && head.mem_write;

  // $zero is never forwarded, so a tag of 0 doubles as "no forward".
  assign fwdHit          = headValid && head.reg_write && (head.rd != '0);
  assign ex_mem_rd       = fwdHit ? head.rd : '0;
  assign ex_mem_fwd_data = fwdHit ? head.alu_result : '0;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: vector table with hand-derived occupancy plus a
// payload scoreboard, then an asynchronous-reset sequence.
module tb_ex_mem_skid_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int BW = 2 * DW + RW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          flush;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic [RW-1:0] ex_mem_rd;
  logic [DW-1:0] ex_mem_fwd_data;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_alu_result   (ex_alu_result),
    .ex_store_data   (ex_store_data),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_alu_result  (mem_alu_result),
    .mem_store_data  (mem_store_data),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_fwd_data (ex_mem_fwd_data),
    .occupancy       (occupancy)
  );

  typedef struct {
    logic          v;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
    logic [DW-1:0] alu;
    logic [DW-1:0] st;
    logic          rdy;
    logic          fl;
    int            expOcc;
  } vec_t;

  vec_t          vecs[$];
  logic [BW-1:0] exp_q[$];
  int            nCmp = 0;
  int            nBad = 0;
  int            occ = 0;

  function automatic vec_t mk(input int v, input int rd, input int rw, input int mr,
                              input int mw, input logic [31:0] alu, input logic [31:0] st,
                              input int rdy, input int fl, input int expOcc);
    vec_t r;
    r.v      = (v != 0);
    r.rd     = RW'(rd);
    r.rw     = (rw != 0);
    r.mr     = (mr != 0);
    r.mw     = (mw != 0);
    r.alu    = alu;
    r.st     = st;
    r.rdy    = (rdy != 0);
    r.fl     = (fl != 0);
    r.expOcc = expOcc;
    return r;
  endfunction

  function automatic logic [BW-1:0] pack(input vec_t r);
    return {r.alu, r.st, r.rd, r.rw, r.mr, r.mw};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the expected occupancy and scoreboard head.
  task automatic checkOutputs(input int o);
    logic [BW-1:0] e;
    logic [RW-1:0] rdE;
    logic [DW-1:0] aluE;
    logic          hit;
    chk("occupancy", BW'(occupancy), BW'(o));
    chk("ex_ready", BW'(ex_ready), BW'(o != 2));
    chk("mem_valid", BW'(mem_valid), BW'(o != 0));
    if (o != 0) begin
      if (exp_q.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL scoreboard: expected occupancy %0d but no bundle queued", o);
      end else begin
        e    = exp_q[0];
        rdE  = e[3 +: RW];
        aluE = e[BW-1 -: DW];
        hit  = e[2] && (rdE != '0);
        chk("head_payload", {mem_alu_result, mem_store_data, mem_rd,
                             mem_reg_write, mem_mem_read, mem_mem_write}, e);
        chk("ex_mem_rd", BW'(ex_mem_rd), hit ? BW'(rdE) : '0);
        chk("ex_mem_fwd_data", BW'(ex_mem_fwd_data), hit ? BW'(aluE) : '0);
      end
    end else begin
      chk("ctrl_gated", BW'({mem_reg_write, mem_mem_read, mem_mem_write}), '0);
      chk("ex_mem_rd_idle", BW'(ex_mem_rd), '0);
      chk("fwd_data_idle", BW'(ex_mem_fwd_data), '0);
    end
  endtask

  task automatic drive(input vec_t r);
    ex_valid      = r.v;
    ex_rd         = r.rd;
    ex_reg_write  = r.rw;
    ex_mem_read   = r.mr;
    ex_mem_write  = r.mw;
    ex_alu_result = r.alu;
    ex_store_data = r.st;
    mem_ready     = r.rdy;
    flush         = r.fl;
  endtask

  // One cycle: check current outputs, drive the row, advance the scoreboard.
  task automatic applyRow(input vec_t r);
    logic popE;
    logic pushE;
    @(negedge clk);
    checkOutputs(occ);
    drive(r);
    popE  = (occ != 0) && r.rdy;
    pushE = r.v && (occ != 2) && !r.fl;
    if (r.fl) begin
      exp_q.delete();
    end else begin
      if (popE) void'(exp_q.pop_front());
      if (pushE) exp_q.push_back(pack(r));
    end
    occ = r.expOcc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    checkOutputs(0);
    chk("reset_payload", BW'({mem_alu_result, mem_store_data, mem_rd}), '0);
    rst_n = 1'b1;

    // Single push, seen the next cycle, gone the cycle after.
    vecs.push_back(mk(1, 5, 1, 0, 0, 'h1234, 'h0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // Fill to FULL, C held off, then drain in order.
    vecs.push_back(mk(1, 1, 1, 0, 0, 'hA, 'h11, 0, 0, 1));
    vecs.push_back(mk(1, 2, 1, 1, 0, 'hB, 'h22, 0, 0, 2));
    vecs.push_back(mk(1, 3, 1, 0, 1, 'hC, 'h33, 0, 0, 2));
    vecs.push_back(mk(1, 3, 1, 0, 1, 'hC, 'h33, 1, 0, 1));
    vecs.push_back(mk(1, 3, 1, 0, 1, 'hC, 'h33, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // Back-to-back stream with MEM always ready.
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                        $urandom, $urandom, 1, 0, 1));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // rd=0 with reg_write passes through but is never a forward.
    vecs.push_back(mk(1, 0, 1, 1, 0, 'hDEAD, 'hBEEF, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // Flush in FULL with a push in the same cycle; pushed bundle must vanish.
    vecs.push_back(mk(1, 9, 1, 0, 1, 'h900, 'h901, 0, 0, 1));
    vecs.push_back(mk(1, 10, 1, 0, 0, 'hA00, 'hA01, 0, 0, 2));
    vecs.push_back(mk(1, 11, 1, 0, 0, 'hB00, 'hB01, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // Flush in ONE together with a pop, then normal operation resumes.
    vecs.push_back(mk(1, 12, 1, 0, 0, 'hC00, 'hC01, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 13, 1, 0, 0, 'hD00, 'hD01, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyRow(vecs[i]);
    end

    // Asynchronous reset between edges while holding one entry.
    applyRow(mk(1, 7, 1, 0, 0, 'h7777, 'h0, 0, 0, 1));
    applyRow(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", BW'(mem_valid), '0);
    chk("async_rst_ex_mem_rd", BW'(ex_mem_rd), '0);
    chk("async_rst_fwd_data", BW'(ex_mem_fwd_data), '0);
    chk("async_rst_occupancy", BW'(occupancy), '0);
    chk("async_rst_ex_ready", BW'(ex_ready), BW'(1));
    chk("async_rst_payload", BW'({mem_alu_result, mem_rd}), '0);
    exp_q.delete();
    occ = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyRow(mk(1, 8, 1, 0, 0, 'h8888, 'h8, 1, 0, 1));
    applyRow(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    checkOutputs(occ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
